// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and helpers
package pipe_pkg;

    // Forwarding-source encodings shared with the hazard unit
    typedef enum logic [1:0] {
        SRC_RF    = 2'd0,
        SRC_EXMEM = 2'd1,
        SRC_MEMWB = 2'd2,
        SRC_IMM   = 2'd3
    } fwd_src_e;

    // Index width for n items, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// rtl/mux_n_1.sv - combinational N:1 selector with range check
module mux_n_1
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        y,
    output logic                    sel_ok
);

    // Widen by one bit so NUM_IN itself is representable in the compare
    logic [SEL_W:0] sel_ext;
    assign sel_ext = {1'b0, in_sel};
    assign sel_ok  = (sel_ext < (SEL_W+1)'(NUM_IN));

    // One-hot decode of the index; an out-of-range index yields zero
    always_comb begin
        y = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                y = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pipe_sel_mux_reg.sv
// rtl/pipe_sel_mux_reg.sv - operand-select mux with stall/flush pipeline register
module pipe_sel_mux_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 8,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    bad_sel,
    output logic [CNT_W-1:0]        bad_cnt
);

    logic [WIDTH-1:0] mux_y;
    logic             sel_ok;
    logic             is_bad;

    mux_n_1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data (in_data),
        .in_sel  (in_sel),
        .y       (mux_y),
        .sel_ok  (sel_ok)
    );

    assign is_bad = in_valid & ~sel_ok;

    // Pipeline register: reset > flush > stall > load; counter only moves on loads
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            bad_sel   <= 1'b0;
            bad_cnt   <= '0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            bad_sel   <= 1'b0;
        end else if (!stall) begin
            out_data  <= sel_ok ? mux_y : '0;
            out_valid <= in_valid;
            out_sel   <= in_sel;
            bad_sel   <= is_bad;
            if (is_bad && (bad_cnt != '1)) begin
                bad_cnt <= bad_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_sel_mux_reg.sv
// tb/tb_pipe_sel_mux_reg.sv - self-checking bench for pipe_sel_mux_reg
module tb_pipe_sel_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Default instance: WIDTH=64, NUM_IN=4, CNT_W=8
    logic         r4 = 1'b1, st4 = 1'b0, fl4 = 1'b0, v4 = 1'b0;
    logic [1:0]   s4 = '0;
    logic [255:0] d4 = '0;
    logic [63:0]  od4;
    logic         ov4, ob4;
    logic [1:0]   os4;
    logic [7:0]   oc4;

    pipe_sel_mux_reg dut4 (
        .clk(clk), .reset(r4), .in_data(d4), .in_sel(s4), .in_valid(v4),
        .stall(st4), .flush(fl4), .out_data(od4), .out_valid(ov4),
        .out_sel(os4), .bad_sel(ob4), .bad_cnt(oc4)
    );

    // Non-power-of-two instance with a tiny counter
    logic         r3 = 1'b1, st3 = 1'b0, fl3 = 1'b0, v3 = 1'b0;
    logic [1:0]   s3 = '0;
    logic [191:0] d3 = '0;
    logic [63:0]  od3;
    logic         ov3, ob3;
    logic [1:0]   os3;
    logic [1:0]   oc3;

    pipe_sel_mux_reg #(.WIDTH(64), .NUM_IN(3), .CNT_W(2)) dut3 (
        .clk(clk), .reset(r3), .in_data(d3), .in_sel(s3), .in_valid(v3),
        .stall(st3), .flush(fl3), .out_data(od3), .out_valid(ov3),
        .out_sel(os3), .bad_sel(ob3), .bad_cnt(oc3)
    );

    // Wide-fan-in instance for the random run
    logic         r8 = 1'b1, st8 = 1'b0, fl8 = 1'b0, v8 = 1'b0;
    logic [2:0]   s8 = '0;
    logic [255:0] d8 = '0;
    logic [31:0]  od8;
    logic         ov8, ob8;
    logic [2:0]   os8;
    logic [7:0]   oc8;

    pipe_sel_mux_reg #(.WIDTH(32), .NUM_IN(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset(r8), .in_data(d8), .in_sel(s8), .in_valid(v8),
        .stall(st8), .flush(fl8), .out_data(od8), .out_valid(ov8),
        .out_sel(os8), .bad_sel(ob8), .bad_cnt(oc8)
    );

    function automatic logic [63:0] src(input int seed, input int k);
        return {32'hDEAD_BEEF, seed[15:0], k[15:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, stall, flush, valid;
        logic [1:0] sel;
        int         seed;
        logic [63:0] e_data;
        logic       e_valid;
        logic [1:0] e_sel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic stall, input logic flush,
                                input logic valid, input logic [1:0] sel, input int seed,
                                input logic [63:0] e_data, input logic e_valid,
                                input logic [1:0] e_sel);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.valid = valid;
        v.sel = sel; v.seed = seed; v.e_data = e_data; v.e_valid = e_valid;
        v.e_sel = e_sel;
        return v;
    endfunction

    task automatic step3(input logic rst, input logic stall, input logic flush,
                         input logic valid, input logic [1:0] sel, input string name,
                         input logic [63:0] e_data, input logic e_valid,
                         input logic [1:0] e_sel, input logic e_bad, input logic [1:0] e_cnt);
        r3 = rst; st3 = stall; fl3 = flush; v3 = valid; s3 = sel;
        @(posedge clk); #1;
        chk(name, {od3, ov3, os3, ob3, oc3}, {e_data, e_valid, e_sel, e_bad, e_cnt});
    endtask

    logic [31:0] m_data;
    logic        m_valid;
    logic [2:0]  m_sel;

    initial begin
        // Reset rows use random sources; all other rows are directed
        tbl.push_back(mk(1, 0, 0, 1, 2'd3, int'($urandom), 64'd0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 1, 1, 2'd1, int'($urandom), 64'd0, 0, 2'd0));
        tbl.push_back(mk(0, 0, 0, 1, 2'd2, 0,  64'hDEAD_BEEF_0000_0002, 1, 2'd2));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 0, 0, 1, 2'(k), k + 1, src(k + 1, k), 1, 2'(k)));
        tbl.push_back(mk(0, 0, 0, 1, 2'd1, 5,  src(5, 1), 1, 2'd1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 0, 0, 2'd3, 6 + k, src(5, 1), 1, 2'd1));
        tbl.push_back(mk(0, 0, 0, 1, 2'd2, 9,  src(9, 2), 1, 2'd2));
        tbl.push_back(mk(0, 1, 1, 1, 2'd3, 10, 64'd0, 0, 2'd0));
        tbl.push_back(mk(0, 0, 0, 1, 2'd0, 11, src(11, 0), 1, 2'd0));
        tbl.push_back(mk(0, 0, 1, 1, 2'd1, 12, 64'd0, 0, 2'd0));
        tbl.push_back(mk(0, 0, 0, 1, 2'd1, 13, src(13, 1), 1, 2'd1));
        tbl.push_back(mk(0, 0, 0, 0, 2'd3, 14, src(14, 3), 0, 2'd3));
        tbl.push_back(mk(1, 1, 0, 1, 2'd2, 15, 64'd0, 0, 2'd0));

        foreach (tbl[i]) begin
            r4 = tbl[i].rst; st4 = tbl[i].stall; fl4 = tbl[i].flush;
            v4 = tbl[i].valid; s4 = tbl[i].sel;
            for (int k = 0; k < 4; k++) d4[k*64 +: 64] = src(tbl[i].seed, k);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), {od4, ov4, os4, ob4, oc4},
                {tbl[i].e_data, tbl[i].e_valid, tbl[i].e_sel, 1'b0, 8'd0});
        end

        // NUM_IN=3: out-of-range selects, saturation, flush keeps the count
        for (int k = 0; k < 3; k++) d3[k*64 +: 64] = src(20, k);
        step3(1, 0, 0, 1, 2'd3, "n3_reset", 64'd0, 0, 2'd0, 0, 2'd0);
        for (int i = 0; i < 5; i++)
            step3(0, 0, 0, 1, 2'd3, $sformatf("n3_bad%0d", i), 64'd0, 1, 2'd3, 1,
                  (i < 3) ? 2'(i + 1) : 2'd3);
        step3(0, 0, 0, 0, 2'd3, "n3_invalid", 64'd0, 0, 2'd3, 0, 2'd3);
        step3(0, 0, 1, 1, 2'd3, "n3_flush", 64'd0, 0, 2'd0, 0, 2'd3);
        step3(0, 0, 0, 1, 2'd2, "n3_good", src(20, 2), 1, 2'd2, 0, 2'd3);
        step3(0, 1, 1, 1, 2'd3, "n3_stallflush", 64'd0, 0, 2'd0, 0, 2'd3);
        step3(0, 1, 0, 1, 2'd3, "n3_stall", 64'd0, 0, 2'd0, 0, 2'd3);
        step3(1, 0, 0, 0, 2'd0, "n3_reset2", 64'd0, 0, 2'd0, 0, 2'd0);

        // NUM_IN=8: random traffic against a reference model
        m_data = '0; m_valid = 1'b0; m_sel = '0;
        for (int c = 0; c < 10000; c++) begin
            r8  = (c == 0) || ($urandom_range(0, 99) < 2);
            st8 = ($urandom_range(0, 3) == 0);
            fl8 = ($urandom_range(0, 9) == 0);
            v8  = 1'($urandom);
            s8  = 3'($urandom);
            for (int k = 0; k < 8; k++) d8[k*32 +: 32] = $urandom;
            if (r8 || fl8) begin
                m_data = '0; m_valid = 1'b0; m_sel = '0;
            end else if (!st8) begin
                m_data = d8[s8*32 +: 32]; m_valid = v8; m_sel = s8;
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d", c), {od8, ov8, os8, ob8, oc8},
                {m_data, m_valid, m_sel, 1'b0, 8'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
